aud_ctrl: RTL and testbench
===========================

Name: aud_ctrl

Overview:
Top-level sequencing FSM for the audio path. Turns user start/pause/stop pulses and a record/play mode select into single-cycle control pulses for AudRecorder and the DSP/AudPlayer. Owns the shared SRAM port mux: the recorder writes during record, the DSP reads otherwise. Latches the recording end address and keeps an elapsed-seconds counter driven by LRC edges.

Parameters:
ADDR_W, 20, SRAM word-address width
MAX_ADDR, 20'hFFFFF, last writable address; recording auto-stops here
SAMPLE_RATE, 32000, LRC rising edges per elapsed second
SEC_W, 10, width of seconds counter

Ports:
i_clk  in  1  system clock (BCLK domain)
i_rst  in  1  synchronous active-high reset
i_mode  in  1  1=record, 0=play; sampled only in IDLE
i_start  in  1  start/resume request, single-cycle pulse
i_pause  in  1  pause request, single-cycle pulse
i_stop  in  1  stop request, single-cycle pulse
i_lrc  in  1  ADC/DAC LR clock (level)
i_rec_addr  in  ADDR_W  current AudRecorder write address
i_play_addr  in  ADDR_W  current DSP read address
i_play_done  in  1  DSP reached end address (level or pulse)
o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder control pulses
o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP control pulses
o_player_en  out  1  AudPlayer enable
o_sram_addr  out  ADDR_W  muxed SRAM address
o_sram_we_n  out  1  SRAM write enable, active low
o_end_addr  out  ADDR_W  last recorded address
o_seconds  out  SEC_W  elapsed seconds
o_state  out  3  IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4

Behaviour:
- One clock, i_clk. i_rst is synchronous and active-high. On reset: state IDLE, all pulse outputs 0, o_player_en 0, o_sram_we_n 1, o_end_addr 0, o_seconds 0, LRC edge register 0, sample counter 0.
- Priority for simultaneous inputs: stop > pause > start. Inputs not legal in the current state are ignored.
- State and pulse outputs are registered. A request sampled at edge N updates the state and raises the pulse after N. The pulse lasts exactly one cycle.
- IDLE:
  - start & mode=1 -> REC, o_rec_start.
  - start & mode=0 & o_end_addr!=0 -> PLAY, o_dsp_start.
  - start & mode=0 & o_end_addr==0 -> stay IDLE, no pulse.
- REC:
  - stop, or i_rec_addr==MAX_ADDR -> IDLE, o_rec_stop, o_end_addr<=i_rec_addr.
  - pause -> REC_PAUSE, o_rec_pause.
- REC_PAUSE:
  - start -> REC, o_rec_start.
  - stop -> IDLE, o_rec_stop, latch o_end_addr.
- PLAY:
  - stop or i_play_done -> IDLE, o_dsp_stop.
  - pause -> PLAY_PAUSE, o_dsp_pause.
- PLAY_PAUSE:
  - start -> PLAY, o_dsp_start.
  - stop -> IDLE, o_dsp_stop.
  - i_play_done is ignored.
- SRAM mux is combinational from the registered state:
  - REC / REC_PAUSE: o_sram_addr=i_rec_addr.
  - Otherwise: o_sram_addr=i_play_addr.
  - o_sram_we_n=0 only in REC.
- o_player_en=1 only in PLAY.
- Timer:
  - LRC rise = i_lrc & ~lrc_q.
  - In REC or PLAY, each rise increments the sample counter. At SAMPLE_RATE-1 the counter wraps to 0 and o_seconds increments; o_seconds saturates at all-ones.
  - Counter and o_seconds hold in the pause states and in IDLE; IDLE shows the last value.
  - The IDLE->REC and IDLE->PLAY transitions clear both the counter and o_seconds.
- Reset mid-operation returns to IDLE immediately and issues no stop pulse. o_end_addr is cleared, so a reset after a recording makes play-start ignored until a new recording.

Test Plan:
- Reset then idle: all outputs at reset values for 10 cycles; i_start with mode=0 -> no pulse, o_state stays 0.
- Record flow (SAMPLE_RATE=4): mode=1, start -> o_rec_start high exactly 1 cycle, o_state=1, o_sram_we_n=0. 8 LRC rises -> o_seconds=2. Stop with i_rec_addr=20'h00123 -> o_rec_stop pulse, o_end_addr=20'h00123, o_state=0, o_sram_we_n=1.
- Pause/resume: in REC, pause -> o_rec_pause, o_state=2, o_sram_we_n=1, o_seconds frozen across 8 LRC rises. Start -> o_rec_start, o_state=1, counting resumes.
- Auto-stop: i_rec_addr driven to MAX_ADDR in REC -> o_rec_stop next cycle, o_end_addr=20'hFFFFF.
- Play flow: after recording, mode=0, start -> o_dsp_start, o_player_en=1, o_sram_addr tracks i_play_addr. Assert i_play_done -> o_dsp_stop, o_state=0. Repeat with i_play_done asserted in PLAY_PAUSE -> stays in state 4.
- Simultaneous and reset: in PLAY, start+pause+stop together -> only o_dsp_stop. In REC, i_rst mid-run -> o_state=0, o_end_addr=0, no o_rec_stop pulse.

Source files
------------

// File: rtl/aud_ctrl.sv
// Audio path sequencer: user start/pause/stop -> one-cycle recorder/DSP pulses, SRAM port mux, end-address latch, elapsed-seconds timer.
// Pulses and state appear one cycle after the request edge; there is no backpressure, and requests not legal in the current state are dropped.
module aud_ctrl #(
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = '1,
  parameter int                SAMPLE_RATE = 32000,
  parameter int                SEC_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic              i_play_done,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_player_en,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [SEC_W-1:0]  o_seconds,
  output logic [2:0]        o_state
);

  localparam int CNT_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rec_start_q, rec_pause_q, rec_stop_q;
  logic               dsp_start_q, dsp_pause_q, dsp_stop_q;
  logic               rec_start_d, rec_pause_d, rec_stop_d;
  logic               dsp_start_d, dsp_pause_d, dsp_stop_d;
  logic               latch_end;
  logic [ADDR_W-1:0]  end_addr_q;
  logic               lrc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEC_W-1:0]   sec_q;
  logic               lrc_rise;
  logic               counting;
  logic               clear_timer;

  always_comb begin
    state_d     = state_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    latch_end   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Play with nothing recorded is silently dropped.
        if (i_start && i_mode) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end else if (i_start && (end_addr_q != '0)) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      S_REC: begin
        if (i_stop || (i_rec_addr == MAX_ADDR)) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          latch_end  = 1'b1;
        end else if (i_pause) begin
          state_d     = S_REC_PAUSE;
          rec_pause_d = 1'b1;
        end
      end
      S_REC_PAUSE: begin
        if (i_stop) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          latch_end  = 1'b1;
        end else if (i_start) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_stop || i_play_done) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_pause) begin
          state_d     = S_PLAY_PAUSE;
          dsp_pause_d = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (i_stop) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_start) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lrc_rise    = i_lrc & ~lrc_q;
  assign counting    = lrc_rise && ((state_q == S_REC) || (state_q == S_PLAY));
  assign clear_timer = (state_q == S_IDLE) && (state_d != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
      end_addr_q  <= '0;
      lrc_q       <= 1'b0;
      cnt_q       <= '0;
      sec_q       <= '0;
    end else begin
      state_q     <= state_d;
      rec_start_q <= rec_start_d;
      rec_pause_q <= rec_pause_d;
      rec_stop_q  <= rec_stop_d;
      dsp_start_q <= dsp_start_d;
      dsp_pause_q <= dsp_pause_d;
      dsp_stop_q  <= dsp_stop_d;
      lrc_q       <= i_lrc;
      if (latch_end) end_addr_q <= i_rec_addr;
      if (clear_timer) begin
        cnt_q <= '0;
        sec_q <= '0;
      end else if (counting) begin
        if (cnt_q == CNT_MAX) begin
          cnt_q <= '0;
          if (sec_q != '1) sec_q <= sec_q + SEC_W'(1);
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // SRAM ownership follows the registered state only.
  assign o_sram_addr = ((state_q == S_REC) || (state_q == S_REC_PAUSE)) ? i_rec_addr : i_play_addr;
  assign o_sram_we_n = (state_q != S_REC);
  assign o_player_en = (state_q == S_PLAY);
  assign o_end_addr  = end_addr_q;
  assign o_seconds   = sec_q;
  assign o_state     = state_q;
  assign o_rec_start = rec_start_q;
  assign o_rec_pause = rec_pause_q;
  assign o_rec_stop  = rec_stop_q;
  assign o_dsp_start = dsp_start_q;
  assign o_dsp_pause = dsp_pause_q;
  assign o_dsp_stop  = dsp_stop_q;

endmodule

// File: tb/tb_aud_ctrl.sv
// Bench for aud_ctrl: directed flows then random traffic, checked every cycle against a session-level model.
module tb_aud_ctrl;
  localparam int AW = 20;
  localparam int SR = 4;
  localparam int SW = 3;
  localparam int SEC_MAX = 7;
  localparam logic [AW-1:0] MAXA = 20'hFFFFF;
  localparam int IDLE = 0, REC = 1, REC_PAUSE = 2, PLAY = 3, PLAY_PAUSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mode, start, pause, stop, lrc, play_done;
  logic [AW-1:0] rec_addr, play_addr;
  logic          rec_start_o, rec_pause_o, rec_stop_o;
  logic          dsp_start_o, dsp_pause_o, dsp_stop_o;
  logic          player_en, sram_we_n;
  logic [AW-1:0] sram_addr, end_addr;
  logic [SW-1:0] seconds;
  logic [2:0]    state;

  aud_ctrl #(.ADDR_W(AW), .MAX_ADDR(MAXA), .SAMPLE_RATE(SR), .SEC_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_lrc(lrc), .i_rec_addr(rec_addr), .i_play_addr(play_addr),
    .i_play_done(play_done),
    .o_rec_start(rec_start_o), .o_rec_pause(rec_pause_o), .o_rec_stop(rec_stop_o),
    .o_dsp_start(dsp_start_o), .o_dsp_pause(dsp_pause_o), .o_dsp_stop(dsp_stop_o),
    .o_player_en(player_en), .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
    .o_end_addr(end_addr), .o_seconds(seconds), .o_state(state)
  );

  int total = 0;
  int bad = 0;

  // Model: session state plus the number of LRC rises counted this session.
  int            m_state = IDLE;
  int            m_rises = 0;
  logic [AW-1:0] m_end = '0;
  logic          m_lrc = 1'b0;
  logic          e_rs, e_rp, e_rx, e_ds, e_dp, e_dx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_update();
    logic rise;
    {e_rs, e_rp, e_rx, e_ds, e_dp, e_dx} = 6'b0;
    if (rst) begin
      m_state = IDLE;
      m_end   = '0;
      m_rises = 0;
      m_lrc   = 1'b0;
      return;
    end
    rise  = lrc && !m_lrc;
    m_lrc = lrc;
    if (rise && (m_state == REC || m_state == PLAY)) m_rises++;
    case (m_state)
      IDLE: begin
        if (start && mode) begin
          m_state = REC; e_rs = 1'b1; m_rises = 0;
        end else if (start && m_end != '0) begin
          m_state = PLAY; e_ds = 1'b1; m_rises = 0;
        end
      end
      REC: begin
        if (stop || rec_addr == MAXA) begin
          m_state = IDLE; e_rx = 1'b1; m_end = rec_addr;
        end else if (pause) begin
          m_state = REC_PAUSE; e_rp = 1'b1;
        end
      end
      REC_PAUSE: begin
        if (stop) begin
          m_state = IDLE; e_rx = 1'b1; m_end = rec_addr;
        end else if (start) begin
          m_state = REC; e_rs = 1'b1;
        end
      end
      PLAY: begin
        if (stop || play_done) begin
          m_state = IDLE; e_dx = 1'b1;
        end else if (pause) begin
          m_state = PLAY_PAUSE; e_dp = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          m_state = IDLE; e_dx = 1'b1;
        end else if (start) begin
          m_state = PLAY; e_ds = 1'b1;
        end
      end
    endcase
  endfunction

  task automatic check_all();
    int exp_sec;
    exp_sec = (m_rises / SR > SEC_MAX) ? SEC_MAX : m_rises / SR;
    chk("state", 32'(state), 32'(m_state));
    chk("rec_start", 32'(rec_start_o), 32'(e_rs));
    chk("rec_pause", 32'(rec_pause_o), 32'(e_rp));
    chk("rec_stop", 32'(rec_stop_o), 32'(e_rx));
    chk("dsp_start", 32'(dsp_start_o), 32'(e_ds));
    chk("dsp_pause", 32'(dsp_pause_o), 32'(e_dp));
    chk("dsp_stop", 32'(dsp_stop_o), 32'(e_dx));
    chk("player_en", 32'(player_en), 32'(m_state == PLAY));
    chk("sram_we_n", 32'(sram_we_n), 32'(m_state != REC));
    chk("sram_addr", 32'(sram_addr),
        32'((m_state == REC || m_state == REC_PAUSE) ? rec_addr : play_addr));
    chk("end_addr", 32'(end_addr), 32'(m_end));
    chk("seconds", 32'(seconds), 32'(exp_sec));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic lrc_rises(input int n);
    for (int i = 0; i < n; i++) begin
      lrc = 1'b1; tick();
      lrc = 1'b0; tick();
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    lrc = 1'b0; play_done = 1'b0; rec_addr = '0; play_addr = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();

    // Play request with nothing recorded.
    mode = 1'b0; start = 1'b1; tick(); tick();
    chk("idle_play_ignored", 32'(state), 32'(IDLE));

    // Record flow.
    mode = 1'b1; start = 1'b1; rec_addr = 20'h00010; tick();
    chk("rec_start_pulse", 32'(rec_start_o), 32'd1);
    chk("rec_we_low", 32'(sram_we_n), 32'd0);
    lrc_rises(8);
    chk("rec_seconds_2", 32'(seconds), 32'd2);
    rec_addr = 20'h00123; stop = 1'b1; tick();
    chk("rec_end_addr", 32'(end_addr), 32'h00123);
    chk("rec_stop_pulse", 32'(rec_stop_o), 32'd1);
    tick();

    // Pause / resume.
    start = 1'b1; tick();
    lrc_rises(5);
    pause = 1'b1; tick();
    chk("pause_state", 32'(state), 32'(REC_PAUSE));
    lrc_rises(8);
    chk("pause_frozen", 32'(seconds), 32'd1);
    start = 1'b1; tick();
    chk("resume_state", 32'(state), 32'(REC));
    lrc_rises(3);
    chk("resume_counts", 32'(seconds), 32'd2);

    // Auto-stop at the last address.
    rec_addr = MAXA; tick();
    chk("auto_stop_pulse", 32'(rec_stop_o), 32'd1);
    chk("auto_stop_end", 32'(end_addr), 32'hFFFFF);
    rec_addr = 20'h00050; tick();

    // Play flow.
    mode = 1'b0; start = 1'b1; play_addr = 20'h00400; tick();
    chk("play_en", 32'(player_en), 32'd1);
    play_addr = 20'h00401; #1;
    chk("play_sram_track", 32'(sram_addr), 32'h00401);
    play_done = 1'b1; tick();
    chk("play_done_stop", 32'(dsp_stop_o), 32'd1);
    play_done = 1'b0;
    start = 1'b1; tick();
    pause = 1'b1; tick();
    play_done = 1'b1; tick(); tick();
    chk("pause_ignores_done", 32'(state), 32'(PLAY_PAUSE));
    play_done = 1'b0; start = 1'b1; tick();

    // All three requests together in PLAY.
    start = 1'b1; pause = 1'b1; stop = 1'b1; tick();
    chk("simul_stop_only", 32'({dsp_start_o, dsp_pause_o, dsp_stop_o}), 32'b001);

    // Reset during a recording.
    mode = 1'b1; start = 1'b1; tick();
    lrc_rises(2);
    rst = 1'b1; tick();
    chk("rst_no_stop", 32'(rec_stop_o), 32'd0);
    chk("rst_end_clear", 32'(end_addr), 32'd0);
    rst = 1'b0; tick();
    mode = 1'b0; start = 1'b1; tick();
    chk("rst_play_ignored", 32'(state), 32'(IDLE));

    // Seconds saturation.
    mode = 1'b1; start = 1'b1; tick();
    lrc_rises(34);
    chk("sec_saturate", 32'(seconds), 32'(SEC_MAX));
    stop = 1'b1; tick();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      mode      = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 5) == 0);
      pause     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      lrc       = 1'($urandom_range(0, 1));
      play_done = ($urandom_range(0, 19) == 0);
      rec_addr  = ($urandom_range(0, 31) == 0) ? MAXA : 20'($urandom_range(0, 4095));
      play_addr = 20'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
